// File: rtl/ut_pkg.sv
// rtl/ut_pkg.sv - shared widths, opcodes and loader state encoding for the UT processor
package ut_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    localparam logic [2:0] OP_NOR  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ADDC = 3'b011;
    localparam logic [2:0] OP_STA  = 3'b100;
    localparam logic [2:0] OP_JCC  = 3'b110;

    typedef enum logic {
        LD_LOAD = 1'b0,
        LD_IDLE = 1'b1
    } ld_state_t;

endpackage

// File: rtl/ut_sync_ram.sv
// rtl/ut_sync_ram.sv - single write port, registered read DEPTH x DATA_W array
module ut_sync_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ut_mem_loader.sv
// rtl/ut_mem_loader.sv - UT program memory with byte-stream boot loader; UT_LOAD_CKSUM_EN adds cksum/cksum_ok
module ut_mem_loader #(
    parameter int ADDR_W = ut_pkg::ADDR_W,
    parameter int DATA_W = ut_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              enable_mem,
    input  logic              w_mem,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              boot,
    output logic              load_done,
    output logic [ADDR_W-1:0] load_count
`ifdef UT_LOAD_CKSUM_EN
    ,
    output logic [DATA_W-1:0] cksum,
    output logic              cksum_ok
`endif
);

    import ut_pkg::*;

    ld_state_t         state;
    ld_state_t         state_nxt;
    logic [ADDR_W-1:0] count_nxt;
    logic              done_nxt;
    logic              ld_accept;
    logic              cpu_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign boot     = (state == LD_LOAD);
    assign in_ready = (state == LD_LOAD);

    // A restart pulse wins over a byte presented in the same cycle.
    assign ld_accept = in_ready & in_valid & ~load_start;
    assign cpu_en    = ce & enable_mem & ~boot;

    always_comb begin
        state_nxt = state;
        count_nxt = load_count;
        done_nxt  = 1'b0;
        case (state)
            LD_LOAD: begin
                if (load_start) begin
                    count_nxt = '0;
                end else if (ld_accept) begin
                    count_nxt = load_count + 1'b1;
                    if (load_count == '1) begin
                        state_nxt = LD_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            LD_IDLE: begin
                if (load_start) begin
                    state_nxt = LD_LOAD;
                    count_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LD_LOAD;
            load_count <= '0;
            load_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_count <= count_nxt;
            load_done  <= done_nxt;
        end
    end

    // boot selects the single write port owner; the two sources never overlap.
    assign ram_we    = ld_accept | (cpu_en & w_mem);
    assign ram_waddr = boot ? load_count : addr;
    assign ram_wdata = boot ? in_data : wdata;

    ut_sync_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (cpu_en & ~w_mem),
        .raddr (addr),
        .rdata (rdata)
    );

`ifdef UT_LOAD_CKSUM_EN
    logic [DATA_W-1:0] cksum_sum;

    assign cksum_sum = cksum + in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum    <= '0;
            cksum_ok <= 1'b0;
        end else if (load_start) begin
            cksum <= '0;
        end else if (ld_accept) begin
            cksum <= cksum_sum;
            if (load_count == '1) begin
                cksum_ok <= (cksum_sum == '0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ut_mem_loader.sv
// tb/tb_ut_mem_loader.sv - randomized self-checking bench for ut_mem_loader (UT_LOAD_CKSUM_EN optional)
module tb_ut_mem_loader;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          enable_mem;
    logic          w_mem;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          load_start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          boot;
    logic          load_done;
    logic [AW-1:0] load_count;
`ifdef UT_LOAD_CKSUM_EN
    logic [DW-1:0] cksum;
    logic          cksum_ok;
`endif

    ut_mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .enable_mem (enable_mem),
        .w_mem      (w_mem),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .boot       (boot),
        .load_done  (load_done),
        .load_count (load_count)
`ifdef UT_LOAD_CKSUM_EN
        ,
        .cksum      (cksum),
        .cksum_ok   (cksum_ok)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] pgm [DEPTH];
    logic [DW-1:0] exp_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input logic c);
        ce = c; enable_mem = 1'b1; w_mem = 1'b0; addr = a;
        tick();
        enable_mem = 1'b0; ce = 1'b1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
        ce = c; enable_mem = 1'b1; w_mem = 1'b1; addr = a; wdata = d;
        tick();
        enable_mem = 1'b0; w_mem = 1'b0; ce = 1'b1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        ce = 1'b1; enable_mem = 1'b0; w_mem = 1'b0; addr = '0; wdata = '0;
        load_start = 1'b0; in_valid = 1'b0; in_data = '0;
        rst = 1'b0;
        #3 rst = 1'b1;
        #4;
        vectors++; if (boot !== 1'b1) begin miscompares++; $display("FAIL reset_boot got %b exp 1", boot); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        vectors++; if (load_count !== '0) begin miscompares++; $display("FAIL reset_load_count got %0d exp 0", load_count); end
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL reset_load_done got %b exp 0", load_done); end
        vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        int sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
                vectors++;
                if (load_count !== AW'(i) || boot !== 1'b1 || load_done !== 1'b0) begin
                    miscompares++; $display("FAIL load_gap i=%0d got count=%0d boot=%b done=%b", i, load_count, boot, load_done);
                end
            end
            pgm[i] = DW'(i);
            push_byte(pgm[i]);
            mdl[i] = pgm[i];
            sum = sum + i;
            vectors++; if (load_done !== 1'(i == DEPTH-1)) begin miscompares++; $display("FAIL load_done i=%0d got %b exp %b", i, load_done, i == DEPTH-1); end
            vectors++; if (boot !== 1'(i != DEPTH-1) || in_ready !== 1'(i != DEPTH-1)) begin miscompares++; $display("FAIL load_boot i=%0d got boot=%b ready=%b", i, boot, in_ready); end
            vectors++; if (load_count !== AW'((i+1) % DEPTH)) begin miscompares++; $display("FAIL load_count i=%0d got %0d exp %0d", i, load_count, (i+1) % DEPTH); end
`ifdef UT_LOAD_CKSUM_EN
            vectors++; if (cksum !== DW'(sum)) begin miscompares++; $display("FAIL load_cksum i=%0d got %h exp %h", i, cksum, DW'(sum)); end
`endif
        end
`ifdef UT_LOAD_CKSUM_EN
        vectors++; if (cksum_ok !== 1'(DW'(sum) == 0)) begin miscompares++; $display("FAIL load_cksum_ok got %b exp %b", cksum_ok, DW'(sum) == 0); end
`endif
        tick();
        vectors++; if (load_done !== 1'b0 || boot !== 1'b0) begin miscompares++; $display("FAIL load_after got done=%b boot=%b exp 0 0", load_done, boot); end
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 4; i++) begin
            push_byte(DW'($urandom));
            vectors++;
            if (load_count !== '0 || in_ready !== 1'b0 || boot !== 1'b0 || load_done !== 1'b0) begin
                miscompares++; $display("FAIL idle_ignore got count=%0d ready=%b boot=%b done=%b", load_count, in_ready, boot, load_done);
            end
        end
    endtask

    task automatic test_read();
        cpu_read(AW'(5), 1'b1);
        vectors++; if (rdata !== 8'h05) begin miscompares++; $display("FAIL read_5 got %h exp 05", rdata); end
        tick();
        vectors++; if (rdata !== 8'h05) begin miscompares++; $display("FAIL read_hold got %h exp 05", rdata); end
        cpu_read(AW'(9), 1'b0);
        vectors++; if (rdata !== 8'h05) begin miscompares++; $display("FAIL read_ce0 got %h exp 05", rdata); end
        for (int i = 0; i < 16; i++) begin
            logic [AW-1:0] a;
            a = AW'($urandom);
            cpu_read(a, 1'b1);
            vectors++; if (rdata !== mdl[a]) begin miscompares++; $display("FAIL read_rand a=%0d got %h exp %h", a, rdata, mdl[a]); end
        end
        exp_rdata = rdata;
    endtask

    task automatic test_write();
        cpu_read(AW'(1), 1'b1);
        exp_rdata = mdl[1];
        cpu_write(AW'(10), 8'hA5, 1'b1);
        mdl[10] = 8'hA5;
        vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL write_rdata_hold got %h exp %h", rdata, exp_rdata); end
        cpu_read(AW'(10), 1'b1);
        vectors++; if (rdata !== 8'hA5) begin miscompares++; $display("FAIL write_readback got %h exp a5", rdata); end
        cpu_write(AW'(10), 8'h5A, 1'b0);
        vectors++; if (rdata !== 8'hA5) begin miscompares++; $display("FAIL write_ce0_rdata got %h exp a5", rdata); end
        cpu_read(AW'(10), 1'b1);
        vectors++; if (rdata !== 8'hA5) begin miscompares++; $display("FAIL write_ce0_mem got %h exp a5", rdata); end
        exp_rdata = 8'hA5;
        for (int i = 0; i < 32; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic          c;
            a = AW'($urandom); d = DW'($urandom); c = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                cpu_write(a, d, c);
                if (c) mdl[a] = d;
            end else begin
                cpu_read(a, c);
                if (c) exp_rdata = mdl[a];
            end
            vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL write_rand i=%0d a=%0d got %h exp %h", i, a, rdata, exp_rdata); end
        end
    endtask

    task automatic test_boot_block();
        pulse_start();
        vectors++; if (boot !== 1'b1 || in_ready !== 1'b1 || load_count !== '0) begin miscompares++; $display("FAIL boot_enter got boot=%b ready=%b count=%0d", boot, in_ready, load_count); end
        for (int i = 0; i < DEPTH; i++) begin
            pgm[i] = DW'($urandom);
            push_byte(pgm[i]);
            if (i == 10) begin
                cpu_write(AW'(3), 8'hFF, 1'b1);
                cpu_read(AW'(7), 1'b1);
                vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL boot_rdata_hold got %h exp %h", rdata, exp_rdata); end
                vectors++; if (load_count !== AW'(11)) begin miscompares++; $display("FAIL boot_count got %0d exp 11", load_count); end
            end
        end
        vectors++; if (load_done !== 1'b1 || boot !== 1'b0) begin miscompares++; $display("FAIL boot_done got done=%b boot=%b exp 1 0", load_done, boot); end
        for (int i = 0; i < DEPTH; i++) mdl[i] = pgm[i];
        cpu_read(AW'(3), 1'b1);
        vectors++; if (rdata !== mdl[3]) begin miscompares++; $display("FAIL boot_mem3 got %h exp %h", rdata, mdl[3]); end
    endtask

    task automatic test_restart();
        pulse_start();
        for (int i = 0; i < 20; i++) push_byte(DW'($urandom));
        vectors++; if (load_count !== AW'(20)) begin miscompares++; $display("FAIL restart_pre got %0d exp 20", load_count); end
        load_start = 1'b1;
        push_byte(8'hEE);
        load_start = 1'b0;
        vectors++; if (load_count !== '0 || boot !== 1'b1 || load_done !== 1'b0) begin miscompares++; $display("FAIL restart_clear got count=%0d boot=%b done=%b", load_count, boot, load_done); end
`ifdef UT_LOAD_CKSUM_EN
        vectors++; if (cksum !== '0) begin miscompares++; $display("FAIL restart_cksum got %h exp 00", cksum); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            pgm[i] = DW'($urandom);
            push_byte(pgm[i]);
            vectors++; if (load_done !== 1'(i == DEPTH-1)) begin miscompares++; $display("FAIL restart_done i=%0d got %b", i, load_done); end
        end
        for (int i = 0; i < DEPTH; i++) mdl[i] = pgm[i];
        for (int i = 0; i < DEPTH; i++) begin
            cpu_read(AW'(i), 1'b1);
            vectors++; if (rdata !== mdl[i]) begin miscompares++; $display("FAIL restart_mem a=%0d got %h exp %h", i, rdata, mdl[i]); end
        end
    endtask

`ifdef UT_LOAD_CKSUM_EN
    task automatic test_cksum();
        int sum = 0;
        int k;
        logic [DW-1:0] delta;
        for (int i = 0; i < DEPTH-2; i++) begin
            pgm[i] = DW'($urandom);
            sum = sum + pgm[i];
        end
        pgm[DEPTH-2] = DW'(8'h37 - sum);
        pgm[DEPTH-1] = 8'hC9;
        for (int pass = 0; pass < 2; pass++) begin
            delta = '0;
            if (pass == 1) begin
                k = $urandom_range(0, DEPTH-1);
                delta = DW'($urandom_range(1, 255));
                pgm[k] = pgm[k] + delta;
            end
            pulse_start();
            for (int i = 0; i < DEPTH; i++) push_byte(pgm[i]);
            vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL cksum_done pass=%0d got %b exp 1", pass, load_done); end
            vectors++; if (cksum !== delta) begin miscompares++; $display("FAIL cksum_value pass=%0d got %h exp %h", pass, cksum, delta); end
            vectors++; if (cksum_ok !== 1'(pass == 0)) begin miscompares++; $display("FAIL cksum_ok pass=%0d got %b exp %b", pass, cksum_ok, pass == 0); end
            push_byte(8'h11);
            vectors++; if (cksum !== delta || cksum_ok !== 1'(pass == 0)) begin miscompares++; $display("FAIL cksum_hold pass=%0d got %h/%b", pass, cksum, cksum_ok); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_idle_ignore();
        test_read();
        test_write();
        test_boot_block();
        test_restart();
`ifdef UT_LOAD_CKSUM_EN
        test_cksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ut_mem_loader.md
Name: ut_mem_loader

Overview:
- Program/data memory for the UT processor.
- Serves the CPU controller's strobe protocol (enable_mem/W_mem, one-cycle read latency) on one side.
- On the other side, a byte-stream boot loader fills memory from a serial receiver.
- Drives the CPU's boot input: high while a program loads, released when memory is full. This is the writer end of the memory the controller reads.

Parameters:
ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
DATA_W, 8, word width (instruction = code_op[DATA_W-1:DATA_W-3] + address field)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ce  in  1  CPU-side clock enable, same as the controller's ce
enable_mem  in  1  CPU memory access strobe
w_mem  in  1  CPU write qualifier (1=write, 0=read)
addr  in  ADDR_W  CPU address (PC or RI address field, already muxed by sel_ADR)
wdata  in  DATA_W  CPU write data (ACCU)
rdata  out  DATA_W  registered read data to RI/R1
load_start  in  1  pulse: begin a new program load
in_valid  in  1  loader byte valid (from UART receiver)
in_data  in  DATA_W  loader byte
in_ready  out  1  loader can accept a byte
boot  out  1  hold CPU in INIT while high
load_done  out  1  one-cycle pulse when the last word is written
load_count  out  ADDR_W  next load address / words loaded so far

Behaviour:
- Reset values:
  - state=LOAD, boot=1, in_ready=1, load_count=0, load_done=0, rdata=0.
  - The memory array is not reset.
  - Loader FSM and checksum registers are updated every clk edge; they are not gated by ce.
- States: LOAD, IDLE.
- LOAD:
  - boot=1, in_ready=1.
  - On in_valid & in_ready: mem[load_count] <= in_data and load_count <= load_count+1 (wraps).
  - Accepting at load_count==DEPTH-1: next state is IDLE, boot=0 and in_ready=0 from the next cycle, load_count wraps to 0, load_done=1 for exactly that one cycle.
- IDLE:
  - boot=0, in_ready=0; in_valid is ignored.
  - load_start moves to LOAD next cycle with load_count=0 and boot=1.
- load_start in LOAD restarts: load_count <= 0, and any byte accepted that same cycle is dropped.
- CPU read:
  - Condition: ce & enable_mem & ~w_mem & ~boot.
  - Effect: rdata <= mem[addr] at the edge. Data is valid in the following cycle (the controller's *_DLY state).
  - rdata holds when there is no read.
- CPU write:
  - Condition: ce & enable_mem & w_mem & ~boot.
  - Effect: mem[addr] <= wdata; rdata unchanged.
- While boot=1, all CPU accesses are ignored: no write, and rdata holds.
- Same-cycle CPU access and loader write cannot coincide, because each is gated by boot.
- ce=0 freezes the CPU side only.
- Single write port, muxed between the CPU and the loader. Read port is synchronous.
- rst during LOAD: returns to LOAD with load_count=0. Memory contents are undefined and must be reloaded.

Optional Feature:
- Macro: UT_LOAD_CKSUM_EN.
- With it defined:
  - Output cksum[DATA_W] is an 8-bit modular sum of all bytes accepted since entering LOAD; cleared on reset and on load_start.
  - Output cksum_ok is registered alongside load_done: 1 when the final sum == 0 (the program's last byte carries the two's-complement checksum).
  - Both outputs hold in IDLE.
- Without it: both ports are absent and no adder logic is generated.

Decomposition:
- Shared package ut_pkg:
  - localparams ADDR_W and DATA_W.
  - Opcode constants OP_NOR=3'b000, OP_ADD=3'b010, OP_ADDC=3'b011, OP_STA=3'b100, OP_JCC=3'b110.
  - Loader state encoding LD_LOAD/LD_IDLE.
- One natural sub-module: ut_sync_ram, a single-write-port, synchronous-read DEPTH x DATA_W array. The loader FSM, write mux and checksum stay in the top module.

Test Plan:
1. Reset, then stream 64 bytes i (value = address i) with in_valid every cycle -> boot=1 throughout; load_done pulses exactly once on the cycle after byte 63; boot=0 and in_ready=0 from that cycle; load_count=0.
2. After load, read with ce=1, enable_mem=1, w_mem=0, addr=5 -> rdata=8'h05 on the next cycle; rdata holds after enable_mem drops.
3. Write addr=10, wdata=8'hA5 (enable_mem=1, w_mem=1), then read addr=10 -> rdata=8'hA5. Repeat with ce=0 -> no write occurs and rdata unchanged.
4. Drive a CPU write (addr=3, 8'hFF) during LOAD -> mem[3] keeps its loader value; rdata unchanged.
5. Assert load_start mid-load after 20 bytes, with in_valid high in the same cycle -> that byte is dropped; load_count=0; 64 more bytes are required before load_done.
6. With UT_LOAD_CKSUM_EN, load 63 bytes summing to 8'h37 followed by 8'hC9 -> cksum=0 and cksum_ok=1 with load_done. Corrupting one byte -> cksum_ok=0.
